// File: rtl/stage_sequencer.sv
// stage_sequencer: five-stage multicycle control-step sequencer.
// Walks each instruction through Fetch, Decode, Execute, Memory and Write Back,
// issuing per-stage register enables and ROM/RAM strobes. Stage 4 holds on
// RAM1_MFC with a timeout guard. Retired instructions are counted.
// Optional feature macro: SINGLE_STEP_EN (adds Step_Mode / Step inputs).
module stage_sequencer #(
  parameter int unsigned MFC_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             Clock,
  input  logic             Reset_L,
  input  logic             Run,
  input  logic             Mem_Op,
  input  logic             Mem_Write,
  input  logic             Writes_RF,
  input  logic             Halt_Instr,
  input  logic             RAM1_MFC,
`ifdef SINGLE_STEP_EN
  input  logic             Step_Mode,
  input  logic             Step,
`endif
  output logic [2:0]       Stage,
  output logic             IR_Enable,
  output logic             PC_Enable,
  output logic             ROM1_Read,
  output logic             RA_Enable,
  output logic             RB_Enable,
  output logic             RZ_Enable,
  output logic             RM_Enable,
  output logic             RAM1_Read,
  output logic             RAM1_Write_L,
  output logic             RY_Enable,
  output logic             RF_WRITE,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_HALT = 3'd7
  } state_t;

  // Wait count of the final permitted Stage 4 cycle without MFC.
  localparam logic [7:0] WAIT_LAST = 8'(MFC_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv;

`ifdef SINGLE_STEP_EN
  logic step_sync_q, step_sync_d;
  logic step_prev_q, step_prev_d;

  // Step edge detector: sample Step, then compare against its previous sample.
  always_comb begin
    step_sync_d = Step;
    step_prev_d = step_sync_q;
  end

  // Edge detector flops.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= step_sync_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign adv = ~Step_Mode | (step_sync_q & ~step_prev_q);
`else
  assign adv = 1'b1;
`endif

  // Next-state, wait counter, sticky timeout and retire counter.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: if (Run) state_d = ST_S1;
      ST_S1:   if (adv) state_d = ST_S2;
      ST_S2:   if (adv) state_d = ST_S3;
      ST_S3: begin
        wait_d = '0;
        if (adv) state_d = ST_S4;
      end
      ST_S4: begin
        if (Mem_Op) begin
          // MFC wins over the timeout even on the last permitted cycle.
          if (RAM1_MFC) begin
            state_d = ST_S5;
          end else if (adv) begin
            if (wait_q == WAIT_LAST) begin
              state_d   = ST_HALT;
              timeout_d = 1'b1;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end
        end else if (adv) begin
          state_d = ST_S5;
        end
      end
      ST_S5: begin
        if (adv) begin
          cnt_d = cnt_q + 1'b1;
          if (Halt_Instr)  state_d = ST_HALT;
          else if (Run)    state_d = ST_S1;
          else             state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobe decode from the registered state; register enables pulse only when advancing.
  always_comb begin
    IR_Enable    = 1'b0;
    PC_Enable    = 1'b0;
    ROM1_Read    = 1'b0;
    RA_Enable    = 1'b0;
    RB_Enable    = 1'b0;
    RZ_Enable    = 1'b0;
    RM_Enable    = 1'b0;
    RAM1_Read    = 1'b0;
    RAM1_Write_L = 1'b1;
    RY_Enable    = 1'b0;
    RF_WRITE     = 1'b0;
    case (state_q)
      ST_S1: begin
        ROM1_Read = 1'b1;
        IR_Enable = adv;
        PC_Enable = adv;
      end
      ST_S2: begin
        RA_Enable = adv;
        RB_Enable = adv;
      end
      ST_S3: begin
        RZ_Enable = adv;
        RM_Enable = adv;
      end
      ST_S4: begin
        if (Mem_Op) begin
          RAM1_Read    = ~Mem_Write;
          RAM1_Write_L = ~Mem_Write;
          RY_Enable    = RAM1_MFC;
        end else begin
          RY_Enable = adv;
        end
      end
      ST_S5:   RF_WRITE = Writes_RF & adv;
      default: ;
    endcase
  end

  assign Stage       = state_q;
  assign Mem_Timeout = timeout_q;
  assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: the stimulus process pushes the
// expected per-cycle outputs, a monitor pops and compares on the falling edge.
module tb_stage_sequencer;

  logic        Clock, Reset_L, Run, Mem_Op, Mem_Write, Writes_RF, Halt_Instr, RAM1_MFC;
  logic [2:0]  Stage;
  logic        IR_Enable, PC_Enable, ROM1_Read, RA_Enable, RB_Enable, RZ_Enable, RM_Enable;
  logic        RAM1_Read, RAM1_Write_L, RY_Enable, RF_WRITE, Mem_Timeout;
  logic [31:0] Instr_Count;

  stage_sequencer #(.MFC_TIMEOUT(16), .CNT_W(32)) dut (
    .Clock(Clock), .Reset_L(Reset_L), .Run(Run), .Mem_Op(Mem_Op), .Mem_Write(Mem_Write),
    .Writes_RF(Writes_RF), .Halt_Instr(Halt_Instr), .RAM1_MFC(RAM1_MFC),
`ifdef SINGLE_STEP_EN
    .Step_Mode(1'b0), .Step(1'b0),
`endif
    .Stage(Stage), .IR_Enable(IR_Enable), .PC_Enable(PC_Enable), .ROM1_Read(ROM1_Read),
    .RA_Enable(RA_Enable), .RB_Enable(RB_Enable), .RZ_Enable(RZ_Enable), .RM_Enable(RM_Enable),
    .RAM1_Read(RAM1_Read), .RAM1_Write_L(RAM1_Write_L), .RY_Enable(RY_Enable),
    .RF_WRITE(RF_WRITE), .Mem_Timeout(Mem_Timeout), .Instr_Count(Instr_Count)
  );

  typedef struct {
    string       name;
    logic [2:0]  stg;
    logic [11:0] vec;
    logic [31:0] cnt;
  } exp_t;

  exp_t  sb[$];
  string cur_tag;
  int    checks = 0;
  int    passes = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Expected strobe vector for a stage with the given inputs, from the stage table.
  function automatic logic [11:0] spec_vec(input logic [2:0] stg, input logic mop, mwr, mfc,
                                           wrf, to);
    logic s1, s2, s3, s4, s5;
    s1 = (stg == 3'd1); s2 = (stg == 3'd2); s3 = (stg == 3'd3);
    s4 = (stg == 3'd4); s5 = (stg == 3'd5);
    return {s1, s1, s1, s2, s2, s3, s3,
            s4 & mop & ~mwr, ~(s4 & mop & mwr), s4 & (mop ? mfc : 1'b1), s5 & wrf, to};
  endfunction

  // One cycle: drive inputs, push what the outputs must be during this cycle.
  task automatic cyc(input logic rst, run, mop, mwr, wrf, hlt, mfc,
                     input logic [2:0] stg, input logic to, input logic [31:0] cnt);
    exp_t e;
    Reset_L = rst; Run = run; Mem_Op = mop; Mem_Write = mwr;
    Writes_RF = wrf; Halt_Instr = hlt; RAM1_MFC = mfc;
    e.name = cur_tag;
    e.stg  = stg;
    e.vec  = spec_vec(stg, mop, mwr, mfc, wrf, to);
    e.cnt  = cnt;
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation.
  initial begin
    exp_t        e;
    logic [11:0] act;
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {IR_Enable, PC_Enable, ROM1_Read, RA_Enable, RB_Enable, RZ_Enable, RM_Enable,
               RAM1_Read, RAM1_Write_L, RY_Enable, RF_WRITE, Mem_Timeout};
        checks++;
        if (Stage === e.stg && act === e.vec && Instr_Count === e.cnt) passes++;
        else $display("FAIL %s: got stage=%0d strobes=%b count=%0d, expected stage=%0d strobes=%b count=%0d",
                      e.name, Stage, act, Instr_Count, e.stg, e.vec, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    Reset_L = 1'b0; Run = 1'b0; Mem_Op = 1'b0; Mem_Write = 1'b0;
    Writes_RF = 1'b0; Halt_Instr = 1'b0; RAM1_MFC = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    cur_tag = "reset";
    cyc(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);

    // Plain ALU instruction with register write; S1 follows S5 directly.
    cur_tag = "alu";
    cyc(1, 1, 0, 0, 1, 0, 0, 3'd0, 0, 0);
    for (int s = 1; s <= 5; s++) cyc(1, 1, 0, 0, 1, 0, 0, 3'(s), 0, 0);

    // Load: MFC on the fourth Stage 4 cycle, RY only on the MFC cycle.
    cur_tag = "load";
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd1, 0, 1);
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd2, 0, 1);
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd3, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 1, 0, 0, 3'd4, 0, 1);
    cyc(1, 1, 1, 0, 1, 0, 1, 3'd4, 0, 1);
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd5, 0, 1);

    // Store with zero-wait MFC, no register write.
    cur_tag = "store";
    cyc(1, 1, 1, 1, 0, 0, 0, 3'd1, 0, 2);
    cyc(1, 1, 1, 1, 0, 0, 0, 3'd2, 0, 2);
    cyc(1, 1, 1, 1, 0, 0, 0, 3'd3, 0, 2);
    cyc(1, 1, 1, 1, 0, 0, 1, 3'd4, 0, 2);
    cyc(1, 1, 1, 1, 0, 0, 0, 3'd5, 0, 2);

    // MFC on the 16th Stage 4 cycle wins over the timeout; Run dropped in S3.
    cur_tag = "mfc_on_last";
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd1, 0, 3);
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd2, 0, 3);
    cyc(1, 0, 1, 0, 1, 0, 0, 3'd3, 0, 3);
    for (int i = 0; i < 15; i++) cyc(1, 0, 1, 0, 1, 0, 0, 3'd4, 0, 3);
    cyc(1, 0, 1, 0, 1, 0, 1, 3'd4, 0, 3);
    cyc(1, 0, 1, 0, 1, 0, 0, 3'd5, 0, 3);
    cur_tag = "run_drop_idle";
    cyc(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 4);

    // HALT instruction parks in state 7 regardless of Run.
    cur_tag = "halt";
    cyc(1, 1, 0, 0, 0, 0, 0, 3'd0, 0, 4);
    for (int s = 1; s <= 4; s++) cyc(1, 1, 0, 0, 0, 0, 0, 3'(s), 0, 4);
    cyc(1, 1, 0, 0, 0, 1, 0, 3'd5, 0, 4);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1, 0, 0, 3'd7, 0, 5);

    // Reset exits HALTED; reset asserted mid-S4 store abandons it at once.
    cur_tag = "reset_mid_s4";
    cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 3'd0, 0, 0);
    for (int s = 1; s <= 4; s++) cyc(1, 1, 1, 1, 0, 0, 0, 3'(s), 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 3'd0, 0, 0);

    // MFC never arrives: timeout after the 16th Stage 4 cycle, sticky until reset.
    cur_tag = "timeout";
    cyc(1, 1, 1, 0, 1, 0, 0, 3'd0, 0, 0);
    for (int s = 1; s <= 3; s++) cyc(1, 1, 1, 0, 1, 0, 0, 3'(s), 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 0, 1, 0, 0, 3'd4, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 1, 0, 1, 3'd7, 1, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clock);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
